uex_mem_access_bridge: RTL and testbench

- RTL endpoint downstream of the uex memory-access services layer.
- Each software thread's read or write call becomes a tagged request on the req channel.
- The block queues requests in a FIFO and issues them one at a time on a simple single-outstanding memory master port.
- It returns the tagged completion on the rsp channel, which the thread scheduler uses to unblock the waiting thread.

---
 rtl/uex_mem_access_bridge.sv | 186 ++++++++++++++++++
 tb/tb_uex_mem_access_bridge.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uex_mem_access_bridge.sv
// uex_mem_access_bridge: queues tagged read/write requests in a FIFO, issues them
// one at a time on a single-outstanding memory master port and returns tagged
// completions in request order.
// Optional response timeout: define UEX_MEM_ACCESS_BRIDGE_TIMEOUT_EN.
module uex_mem_access_bridge #(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned TID_W   = 4,
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned TIMEOUT = 256
) (
   input  logic                      clock,
   input  logic                      reset_n,
   // request channel
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic                      req_write,
   input  logic [ADDR_W-1:0]         req_addr,
   input  logic [DATA_W-1:0]         req_wdata,
   input  logic [DATA_W/8-1:0]       req_wstrb,
   input  logic [TID_W-1:0]          req_tid,
   // memory master port
   output logic                      m_valid,
   input  logic                      m_ready,
   output logic                      m_write,
   output logic [ADDR_W-1:0]         m_addr,
   output logic [DATA_W-1:0]         m_wdata,
   output logic [DATA_W/8-1:0]       m_wstrb,
   input  logic                      m_rvalid,
   input  logic [DATA_W-1:0]         m_rdata,
   input  logic                      m_rerr,
   // completion channel
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [TID_W-1:0]          rsp_tid,
   output logic                      rsp_write,
   output logic [DATA_W-1:0]         rsp_rdata,
   output logic                      rsp_err,
   // status
   output logic [$clog2(DEPTH):0]    level,
   output logic                      proto_err
);

   localparam int unsigned STRB_W = DATA_W / 8;
   localparam int unsigned PTR_W  = $clog2(DEPTH);
   localparam int unsigned LVL_W  = PTR_W + 1;

   typedef struct packed {
      logic              write;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
      logic [STRB_W-1:0] wstrb;
      logic [TID_W-1:0]  tid;
   } req_t;

   typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_WAIT, ST_RSP} state_t;

   state_t            state_q, state_d;
   req_t              fifo_q [DEPTH];
   req_t              cmd_q;
   logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
   logic [LVL_W-1:0]  level_q;
   logic [TID_W-1:0]  rsp_tid_q;
   logic              rsp_write_q, rsp_err_q, proto_err_q;
   logic [DATA_W-1:0] rsp_rdata_q;

   logic push_c, pop_c, cap_c, tmo_c, enter_wait_c, tmo_hit_c;

   assign req_ready = (level_q != LVL_W'(DEPTH));
   assign push_c    = req_valid && req_ready;

   // Optional response-timeout counter; restarts on every entry to WAIT_RSP.
`ifdef UEX_MEM_ACCESS_BRIDGE_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
   logic [CNT_W-1:0] tmo_cnt_q;

   assign tmo_hit_c = (tmo_cnt_q == CNT_W'(TIMEOUT - 1));

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)                tmo_cnt_q <= '0;
      else if (enter_wait_c)       tmo_cnt_q <= '0;
      else if (state_q == ST_WAIT) tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
   end
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT != 0);
   assign tmo_hit_c      = 1'b0;
`endif

   // Next-state and transaction-step decode.
   always_comb begin
      state_d      = state_q;
      pop_c        = 1'b0;
      cap_c        = 1'b0;
      tmo_c        = 1'b0;
      enter_wait_c = 1'b0;
      unique case (state_q)
         ST_IDLE: if (level_q != '0) begin
            pop_c   = 1'b1;
            state_d = ST_ADDR;
         end
         ST_ADDR: if (m_ready) begin
            enter_wait_c = 1'b1;
            state_d      = ST_WAIT;
         end
         ST_WAIT: begin
            if (m_rvalid) begin
               cap_c   = 1'b1;
               state_d = ST_RSP;
            end else if (tmo_hit_c) begin
               tmo_c   = 1'b1;
               state_d = ST_RSP;
            end
         end
         ST_RSP: if (rsp_ready) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   // FIFO storage; contents need no reset, pointers qualify them.
   always_ff @(posedge clock) begin
      if (push_c) fifo_q[wr_ptr_q] <= '{write: req_write, addr: req_addr, wdata: req_wdata,
                                        wstrb: req_wstrb, tid: req_tid};
   end

   // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (push_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop_c)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         if (push_c && !pop_c)      level_q <= level_q + LVL_W'(1);
         else if (pop_c && !push_c) level_q <= level_q - LVL_W'(1);
      end
   end

   // Command registers drive the bus fields for the whole ADDR phase.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)   cmd_q <= '0;
      else if (pop_c) cmd_q <= fifo_q[rd_ptr_q];
   end

   // Completion registers, held through RSP until accepted.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rsp_tid_q   <= '0;
         rsp_write_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else if (cap_c || tmo_c) begin
         rsp_tid_q   <= cmd_q.tid;
         rsp_write_q <= cmd_q.write;
         rsp_rdata_q <= (cmd_q.write || tmo_c) ? '0 : m_rdata;
         rsp_err_q   <= tmo_c ? 1'b1 : m_rerr;
      end
   end

   // Sticky flag for completions arriving when none is awaited.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)                            proto_err_q <= 1'b0;
      else if (m_rvalid && state_q != ST_WAIT) proto_err_q <= 1'b1;
   end

   assign m_valid   = (state_q == ST_ADDR);
   assign m_write   = cmd_q.write;
   assign m_addr    = cmd_q.addr;
   assign m_wdata   = cmd_q.wdata;
   assign m_wstrb   = cmd_q.wstrb;
   assign rsp_valid = (state_q == ST_RSP);
   assign rsp_tid   = rsp_tid_q;
   assign rsp_write = rsp_write_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;
   assign level     = level_q;
   assign proto_err = proto_err_q;

endmodule

// File: tb/tb_uex_mem_access_bridge.sv
// Bench for uex_mem_access_bridge: directed vector table, hand-written corner
// sequences (fill/backpressure, stray completion, reset mid-flight) and a
// randomized run scored against an in-order queue model.
module tb_uex_mem_access_bridge;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned TID_W  = 4;
   localparam int unsigned DEPTH  = 4;
   localparam int unsigned STRB_W = DATA_W / 8;
   localparam int unsigned LVL_W  = $clog2(DEPTH) + 1;

   logic              clock = 1'b0;
   logic              reset_n;
   logic              req_valid, req_ready, req_write;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic [STRB_W-1:0] req_wstrb;
   logic [TID_W-1:0]  req_tid;
   logic              m_valid, m_ready, m_write;
   logic [ADDR_W-1:0] m_addr;
   logic [DATA_W-1:0] m_wdata;
   logic [STRB_W-1:0] m_wstrb;
   logic              m_rvalid, m_rerr;
   logic [DATA_W-1:0] m_rdata;
   logic              rsp_valid, rsp_ready, rsp_write, rsp_err;
   logic [TID_W-1:0]  rsp_tid;
   logic [DATA_W-1:0] rsp_rdata;
   logic [LVL_W-1:0]  level;
   logic              proto_err;

   uex_mem_access_bridge dut (
      .clock(clock), .reset_n(reset_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_tid(req_tid),
      .m_valid(m_valid), .m_ready(m_ready), .m_write(m_write), .m_addr(m_addr),
      .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
      .m_rerr(m_rerr), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_tid(rsp_tid),
      .rsp_write(rsp_write), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .level(level), .proto_err(proto_err)
   );

   always #5 clock = ~clock;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic              write;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
      logic [STRB_W-1:0] wstrb;
      logic [TID_W-1:0]  tid;
      logic [DATA_W-1:0] bus_rdata;
      logic              bus_rerr;
      logic [DATA_W-1:0] exp_rdata;
      logic              exp_err;
   } vec_t;

   typedef struct packed {
      logic              wr;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
      logic [STRB_W-1:0] wstrb;
      logic [TID_W-1:0]  tid;
   } cmd_t;

   typedef struct packed {
      logic [TID_W-1:0]  tid;
      logic              wr;
      logic [DATA_W-1:0] rdata;
      logic              err;
   } cpl_t;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_inputs();
      req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
      req_wstrb = '0;   req_tid = '0;     m_ready = 1'b0; m_rvalid = 1'b0;
      m_rdata = '0;     m_rerr = 1'b0;    rsp_ready = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset_n = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      reset_n = 1'b1;
   endtask

   // Serve the transaction currently heading for the bus and check its completion.
   task automatic service(input logic [TID_W-1:0] tid, input logic wr,
                          input logic [DATA_W-1:0] rdata, input logic rerr, input int hold);
      int n;
      n = 0;
      while (!m_valid && n < 50) begin tick(); n++; end
      chk("svc_m_valid", m_valid, 1);
      m_ready = 1'b1;
      tick();
      m_ready = 1'b0;
      chk("svc_m_valid_drop", m_valid, 0);
      tick();
      m_rvalid = 1'b1; m_rdata = rdata; m_rerr = rerr;
      tick();
      m_rvalid = 1'b0; m_rerr = 1'b0;
      chk("svc_rsp_valid", rsp_valid, 1);
      chk("svc_rsp_tid", rsp_tid, tid);
      chk("svc_rsp_write", rsp_write, wr);
      chk("svc_rsp_rdata", rsp_rdata, wr ? '0 : rdata);
      chk("svc_rsp_err", rsp_err, rerr);
      for (int i = 0; i < hold; i++) begin
         tick();
         chk("hold_rsp_valid", rsp_valid, 1);
         chk("hold_rsp_tid", rsp_tid, tid);
         chk("hold_rsp_rdata", rsp_rdata, wr ? '0 : rdata);
         chk("hold_no_m_valid", m_valid, 0);
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      chk("svc_rsp_done", rsp_valid, 0);
   endtask

   // One request into an idle block: checks latency and bus fields, then completion.
   task automatic apply_vec(input vec_t v);
      req_valid = 1'b1; req_write = v.write; req_addr = v.addr;
      req_wdata = v.wdata; req_wstrb = v.wstrb; req_tid = v.tid;
      chk("vec_req_ready", req_ready, 1);
      tick();
      req_valid = 1'b0;
      chk("vec_m_valid_n1", m_valid, 0);
      tick();
      chk("vec_m_valid_n2", m_valid, 1);
      chk("vec_m_write", m_write, v.write);
      chk("vec_m_addr", m_addr, v.addr);
      chk("vec_m_wdata", m_wdata, v.wdata);
      chk("vec_m_wstrb", m_wstrb, v.wstrb);
      service(v.tid, v.write, v.bus_rdata, v.bus_rerr, 0);
      chk("vec_rsp_rdata", rsp_rdata, v.exp_rdata);
      chk("vec_rsp_err", rsp_err, v.exp_err);
   endtask

   vec_t vecs [4];
   cmd_t cmd_q [$];
   cpl_t cpl_q [$];

   initial begin
      int   n, sent, done, fire_at;
      logic pend, busy, seen;
      cmd_t pcmd, ecmd;
      cpl_t ecpl;
      logic [DATA_W-1:0] bus_rdata;
      logic bus_err;

      vecs[0] = '{1'b0, 32'h100, 32'h0,    4'h0, 4'd3,  32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 1'b0};
      vecs[1] = '{1'b1, 32'h200, 32'h1234, 4'h3, 4'd5,  32'hFFFFFFFF, 1'b0, 32'h0,        1'b0};
      vecs[2] = '{1'b0, 32'h8,   32'h0,    4'hF, 4'd15, 32'h0000A5A5, 1'b1, 32'h0000A5A5, 1'b1};
      vecs[3] = '{1'b1, 32'hFFC, 32'hCAFE, 4'hC, 4'd0,  32'h12345678, 1'b1, 32'h0,        1'b1};

      do_reset();

      // reset state
      chk("rst_req_ready", req_ready, 1);
      chk("rst_m_valid", m_valid, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_level", level, 0);
      chk("rst_proto_err", proto_err, 0);
      chk("rst_m_addr", m_addr, 0);
      chk("rst_rsp_tid", rsp_tid, 0);

      // table-driven transactions
      for (int i = 0; i < 4; i++) apply_vec(vecs[i]);
      chk("vec_proto_clean", proto_err, 0);

      // stray completion while idle is sticky and otherwise ignored
      m_rvalid = 1'b1; m_rdata = 32'h55; m_rerr = 1'b1;
      tick();
      m_rvalid = 1'b0; m_rerr = 1'b0;
      chk("stray_proto_err", proto_err, 1);
      chk("stray_no_rsp", rsp_valid, 0);
      repeat (3) tick();
      chk("stray_sticky", proto_err, 1);
      apply_vec(vecs[0]);
      chk("stray_sticky2", proto_err, 1);

      // fill with the bus stalled, then drain with response backpressure
      for (int i = 0; i < 5; i++) begin
         req_valid = 1'b1; req_write = 1'b0; req_addr = 32'(i * 4); req_tid = 4'(i);
         n = 0;
         while (!req_ready && n < 20) begin tick(); n++; end
         tick();
      end
      req_valid = 1'b0;
      chk("fill_level", level, 4);
      chk("fill_req_ready", req_ready, 0);
      chk("fill_m_valid", m_valid, 1);
      chk("fill_m_addr", m_addr, 0);
      service(4'd0, 1'b0, 32'hA0, 1'b0, 10);
      for (int i = 1; i < 5; i++) service(4'(i), 1'b0, 32'(32'hA0 + i), 1'b0, 0);
      chk("drain_level", level, 0);
      chk("drain_req_ready", req_ready, 1);

      // reset while a transaction waits for its completion
      req_valid = 1'b1; req_tid = 4'd7; req_addr = 32'h40;
      tick();
      req_tid = 4'd8;
      tick();
      req_valid = 1'b0;
      n = 0;
      while (!m_valid && n < 20) begin tick(); n++; end
      m_ready = 1'b1;
      tick();
      m_ready = 1'b0;
      #2;
      reset_n = 1'b0;
      #1;
      chk("mid_rst_m_valid", m_valid, 0);
      chk("mid_rst_rsp_valid", rsp_valid, 0);
      chk("mid_rst_req_ready", req_ready, 1);
      chk("mid_rst_level", level, 0);
      chk("mid_rst_proto_err", proto_err, 0);
      chk("mid_rst_m_addr", m_addr, 0);
      tick();
      reset_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (m_valid || rsp_valid) seen = 1'b1;
      end
      chk("mid_rst_no_activity", seen, 0);

      // randomized traffic against an in-order queue model
      pend = 1'b0; busy = 1'b0; sent = 0; done = 0; fire_at = 0;
      pcmd = '0; bus_rdata = '0; bus_err = 1'b0;
      for (int cyc = 0; cyc < 6000 && done < 60; cyc++) begin
         tick();
         if (!pend && sent < 60 && $urandom_range(0, 1) == 1) begin
            pcmd = '{wr: 1'($urandom_range(0, 1)), addr: $urandom, wdata: $urandom,
                     wstrb: 4'($urandom), tid: 4'($urandom)};
            pend = 1'b1;
         end
         req_valid = pend; req_write = pcmd.wr; req_addr = pcmd.addr;
         req_wdata = pcmd.wdata; req_wstrb = pcmd.wstrb; req_tid = pcmd.tid;
         m_ready   = 1'($urandom_range(0, 1));
         rsp_ready = 1'($urandom_range(0, 1));
         if (busy && cyc == fire_at) begin
            m_rvalid = 1'b1; m_rdata = bus_rdata; m_rerr = bus_err; busy = 1'b0;
         end else begin
            m_rvalid = 1'b0; m_rdata = $urandom; m_rerr = 1'b0;
         end
         #1;
         if (req_valid && req_ready) begin
            cmd_q.push_back(pcmd);
            pend = 1'b0;
            sent++;
         end
         if (m_valid && m_ready) begin
            chk("rnd_single_outstanding", busy, 0);
            chk("rnd_cmd_expected", cmd_q.size() != 0, 1);
            if (cmd_q.size() != 0) begin
               ecmd = cmd_q.pop_front();
               chk("rnd_m_write", m_write, ecmd.wr);
               chk("rnd_m_addr", m_addr, ecmd.addr);
               chk("rnd_m_wdata", m_wdata, ecmd.wdata);
               chk("rnd_m_wstrb", m_wstrb, ecmd.wstrb);
               busy      = 1'b1;
               fire_at   = cyc + int'($urandom_range(1, 4));
               bus_rdata = $urandom;
               bus_err   = ($urandom_range(0, 7) == 0);
               cpl_q.push_back('{tid: ecmd.tid, wr: ecmd.wr,
                                 rdata: ecmd.wr ? '0 : bus_rdata, err: bus_err});
            end
         end
         if (rsp_valid && rsp_ready) begin
            chk("rnd_cpl_expected", cpl_q.size() != 0, 1);
            if (cpl_q.size() != 0) begin
               ecpl = cpl_q.pop_front();
               chk("rnd_rsp_tid", rsp_tid, ecpl.tid);
               chk("rnd_rsp_write", rsp_write, ecpl.wr);
               chk("rnd_rsp_rdata", rsp_rdata, ecpl.rdata);
               chk("rnd_rsp_err", rsp_err, ecpl.err);
            end
            done++;
         end
      end
      idle_inputs();
      chk("rnd_all_done", done, 60);
      chk("rnd_proto_clean", proto_err, 0);
      chk("rnd_level_empty", level, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
